// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared op encoding and width helper for the program counter
package pc_pkg;

  // One operation is selected per cycle from the control strobes.
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_CALL,
    PC_JMP,
    PC_RET,
    PC_INC
  } pc_op_e;

  // Width needed to hold an entry count from 0 up to and including depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - parametrised LIFO of return addresses
module ret_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5,
  parameter int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  // The next free slot is the current count; the top entry sits just below it.
  assign wr_idx = IW'(count);
  assign rd_idx = IW'(count - CW'(1));
  assign top    = mem[rd_idx];
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);

  // Entry storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

  // Occupancy counter; a push to a full stack or a pop from an empty one is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with return-address stack; PC_REL_BRANCH_EN adds relative targets
module pc_stack
  import pc_pkg::*;
#(
  parameter int                         INSTR_ADDR_SIZE = 5,
  parameter int                         STACK_DEPTH     = 4,
  parameter logic [INSTR_ADDR_SIZE-1:0] RESET_ADDR      = '0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  stall,
  input  logic                                  jmp,
  input  logic                                  call,
  input  logic                                  ret,
`ifdef PC_REL_BRANCH_EN
  input  logic                                  rel,
`endif
  input  logic [INSTR_ADDR_SIZE-1:0]            jmp_addr,
  output logic [INSTR_ADDR_SIZE-1:0]            instr_addr,
  output logic [count_width(STACK_DEPTH)-1:0]   stack_count,
  output logic                                  stack_full,
  output logic                                  stack_empty,
  output logic                                  stack_err
);

  localparam int W = INSTR_ADDR_SIZE;

  pc_op_e       op;
  logic [W-1:0] target;
  logic [W-1:0] ret_top;
  logic [W-1:0] addr_next;
  logic         push;
  logic         pop;
  logic         err_set;

  // Strobe priority: stall, then call, jmp, ret, else increment.
  always_comb begin
    op = PC_INC;
    if (stall) begin
      op = PC_HOLD;
    end else if (call) begin
      op = PC_CALL;
    end else if (jmp) begin
      op = PC_JMP;
    end else if (ret) begin
      op = PC_RET;
    end
  end

`ifdef PC_REL_BRANCH_EN
  // Relative targets add a two's-complement offset; the sum wraps at the address width.
  always_comb begin
    target = jmp_addr;
    if (rel) begin
      target = instr_addr + jmp_addr;
    end
  end
`else
  // Targets are always absolute.
  always_comb begin
    target = jmp_addr;
  end
`endif

  // Stack side effects and the error condition for the selected op.
  always_comb begin
    push    = (op == PC_CALL) && !stack_full;
    pop     = (op == PC_RET) && !stack_empty;
    err_set = ((op == PC_CALL) && stack_full) || ((op == PC_RET) && stack_empty);
  end

  // Next instruction address; a return resumes after the stored call site.
  always_comb begin
    addr_next = instr_addr + W'(1);
    case (op)
      PC_HOLD: addr_next = instr_addr;
      PC_CALL: addr_next = target;
      PC_JMP:  addr_next = target;
      PC_RET:  addr_next = stack_empty ? (instr_addr + W'(1)) : (ret_top + W'(1));
      default: addr_next = instr_addr + W'(1);
    endcase
  end

  // Address register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_addr <= RESET_ADDR;
    end else begin
      instr_addr <= addr_next;
    end
  end

  // Sticky overflow/underflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stack_err <= 1'b0;
    end else if (err_set) begin
      stack_err <= 1'b1;
    end
  end

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (W),
    .CW    (count_width(STACK_DEPTH))
  ) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (instr_addr),
    .top       (ret_top),
    .count     (stack_count),
    .full      (stack_full),
    .empty     (stack_empty)
  );

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - scoreboard bench for pc_stack (PC_REL_BRANCH_EN optional)
module tb_pc_stack;

  localparam int W  = 5;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);
  localparam int M  = 1 << W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          jmp = 1'b0;
  logic          call = 1'b0;
  logic          ret = 1'b0;
  logic [W-1:0]  jmp_addr = '0;
`ifdef PC_REL_BRANCH_EN
  logic          rel = 1'b0;
`endif
  logic [W-1:0]  instr_addr;
  logic [CW-1:0] stack_count;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_err;

  pc_stack #(
    .INSTR_ADDR_SIZE (W),
    .STACK_DEPTH     (D),
    .RESET_ADDR      ('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jmp         (jmp),
    .call        (call),
    .ret         (ret),
`ifdef PC_REL_BRANCH_EN
    .rel         (rel),
`endif
    .jmp_addr    (jmp_addr),
    .instr_addr  (instr_addr),
    .stack_count (stack_count),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int cnt;
    bit full;
    bit empty;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  int   m_addr;
  int   m_stk[$];
  bit   m_err;
  int   checks = 0;
  int   errors = 0;

  function automatic void model_reset();
    m_addr = 0;
    m_stk.delete();
    m_err = 1'b0;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.addr  = m_addr;
    e.cnt   = m_stk.size();
    e.full  = (m_stk.size() == D);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    exp_q.push_back(e);
  endfunction

  function automatic void model_step(bit s, bit c, bit j, bit r, int ja, bit rl);
    int tgt;
    tgt = rl ? ((m_addr + ja) % M) : ja;
    if (s) begin
      // nothing changes
    end else if (c) begin
      if (m_stk.size() < D) m_stk.push_back(m_addr);
      else m_err = 1'b1;
      m_addr = tgt;
    end else if (j) begin
      m_addr = tgt;
    end else if (r) begin
      if (m_stk.size() > 0) m_addr = (m_stk.pop_back() + 1) % M;
      else begin
        m_err  = 1'b1;
        m_addr = (m_addr + 1) % M;
      end
    end else begin
      m_addr = (m_addr + 1) % M;
    end
  endfunction

  task automatic cycle(input bit s, input bit c, input bit j, input bit r, input int ja, input bit rl);
    bit rl_eff;
    @(negedge clk);
    rst      = 1'b0;
    stall    = s;
    call     = c;
    jmp      = j;
    ret      = r;
    jmp_addr = W'(ja);
`ifdef PC_REL_BRANCH_EN
    rel    = rl;
    rl_eff = rl;
`else
    rl_eff = 1'b0;
    if (rl) rl_eff = 1'b0;
`endif
    model_step(s, c, j, r, ja, rl_eff);
    push_exp();
  endtask

  task automatic inc();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  // Reset with strobes active shows reset outranks everything.
  task automatic reset_cycle();
    @(negedge clk);
    stall    = 1'b0;
    call     = 1'b1;
    jmp      = 1'b1;
    ret      = 1'b1;
    jmp_addr = W'($urandom_range(0, M - 1));
    model_reset();
    push_exp();
    rst = 1'b1;
  endtask

  // Raise reset between edges; the monitor samples before the next edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    model_reset();
    push_exp();
    rst = 1'b1;
  endtask

  // Monitor: every clock edge or reset assertion presents a new output state.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (int'(instr_addr) != e.addr) begin
          errors++;
          $display("FAIL instr_addr at %0t: got %0d expected %0d", $time, instr_addr, e.addr);
        end
        checks++;
        if (int'(stack_count) != e.cnt || stack_full != e.full || stack_empty != e.empty || stack_err != e.err) begin
          errors++;
          $display("FAIL status at %0t: got cnt=%0d full=%0b empty=%0b err=%0b expected cnt=%0d full=%0b empty=%0b err=%0b",
                   $time, stack_count, stack_full, stack_empty, stack_err, e.cnt, e.full, e.empty, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset_cycle();
    // free run 0,1,2,3
    inc(); inc(); inc();
    // call at 3 -> 20, ret at 21 -> 4
    cycle(0, 1, 0, 0, 20, 0);
    inc();
    cycle(0, 0, 0, 1, 0, 0);
    // nested calls 1->10, 11->15, 16->25 then three returns: 17, 12, 2
    cycle(0, 0, 1, 0, 1, 0);
    cycle(0, 1, 0, 0, 10, 0);
    inc();
    cycle(0, 1, 0, 0, 15, 0);
    inc();
    cycle(0, 1, 0, 0, 25, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    // fill all entries, overflow with target 7, then return to 4th caller + 1
    cycle(0, 1, 0, 0, 5, 0);
    cycle(0, 1, 0, 0, 9, 0);
    cycle(0, 1, 0, 0, 13, 0);
    cycle(0, 1, 1, 1, 17, 0);
    cycle(0, 1, 0, 0, 7, 0);
    cycle(0, 0, 0, 1, 0, 0);
    // underflow at 31 wraps to 0; stall with call holds everything
    reset_cycle();
    cycle(0, 0, 1, 0, 31, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 1, 0, 0, 9, 0);
    cycle(1, 0, 0, 1, 0, 0);
    inc();
`ifdef PC_REL_BRANCH_EN
    // relative jump at 10 by -3 -> 7; rel on ret is ignored
    reset_cycle();
    cycle(0, 0, 1, 0, 10, 0);
    cycle(0, 0, 1, 0, 5'b11101, 1);
    cycle(0, 1, 0, 0, 4, 1);
    cycle(0, 0, 0, 1, 3, 1);
`endif
    // asynchronous reset in the middle of a call sequence
    cycle(0, 1, 0, 0, 12, 0);
    cycle(0, 1, 0, 0, 22, 0);
    async_reset();
    reset_cycle();
    inc();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        reset_cycle();
      end else begin
        cycle(($urandom_range(0, 9) == 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 2) == 0),
              int'($urandom_range(0, M - 1)),
              ($urandom_range(0, 1) == 1));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with an integrated hardware return-address stack. Sequences the instruction address for the core: it increments, jumps, calls (pushing the caller's address) and returns (popping and resuming after the call site). It also supports stall and reports stack status. It sits between the decoder (control strobes, target address) and instruction memory (address).

## Interface
- INSTR_ADDR_SIZE, 5: width of the instruction address.
- STACK_DEPTH, 4: number of return-address entries; must be ≥ 2.
- RESET_ADDR, 0: value loaded into instr_addr on reset.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- stall  input  1  hold instr_addr and stack unchanged this cycle.
- jmp  input  1  load jmp_addr.
- call  input  1  push current instr_addr, then load jmp_addr.
- ret  input  1  pop top entry, load popped value + 1.
- jmp_addr  input  INSTR_ADDR_SIZE  target for jmp/call.
- instr_addr  output  INSTR_ADDR_SIZE  current instruction address.
- stack_count  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  stack_count == STACK_DEPTH.
- stack_empty  output  1  stack_count == 0.
- stack_err  output  1  sticky; set on overflow or underflow, cleared only by rst.

## Operation
- Priority per cycle: rst > stall > call > jmp > ret > increment. Lower-priority strobes asserted in the same cycle are ignored without error.
- Increment: instr_addr ← instr_addr + 1, modulo 2^INSTR_ADDR_SIZE (all-ones wraps to 0).
- jmp: instr_addr ← jmp_addr; stack untouched.
- call, not full: push the current instr_addr, count +1, instr_addr ← jmp_addr.
- call when full (overflow): the push is dropped and the stack is unchanged. The jump is still taken and stack_err is set.
- ret, not empty: pop the top entry, count −1, instr_addr ← popped + 1, with the same modulo wrap.
- ret when empty (underflow): behaves as increment and stack_err is set.
- stall: no state changes, including stack_err. A stall suppresses any error condition in that cycle.
- Control-select encoding: pc_op_e = {PC_HOLD, PC_CALL, PC_JMP, PC_RET, PC_INC}, decoded once per cycle from the strobes using the priority above.
- Stack storage holds raw return addresses (the call-site address). The +1 is applied on return.

## Timing
- Reset (async assert; release synchronised by the system): instr_addr = RESET_ADDR, stack_count = 0, stack_empty = 1, stack_full = 0, stack_err = 0. Stack contents are don't-care.
- Reset asserted mid-sequence clears the stack immediately, regardless of pending strobes.
- Latency: every strobe takes effect on instr_addr at the next rising edge (1 cycle). There is no combinational path from inputs to instr_addr.
- stack_count, stack_full and stack_empty are registered or derived from registered count. They reflect the post-edge state in the same cycle as instr_addr.
- stack_err rises on the edge that performs the faulting call or ret.
- Back-to-back call/ret on consecutive cycles is fully supported: the pop in cycle N+1 returns the address pushed in cycle N.

## Configuration
- PC_REL_BRANCH_EN: when defined, adds the input `rel` (1 bit). When rel=1 together with jmp or call, the target is instr_addr + jmp_addr, with jmp_addr treated as two's-complement and the sum taken modulo 2^INSTR_ADDR_SIZE.
- rel has no effect on ret or increment.
- When PC_REL_BRANCH_EN is undefined, the `rel` port does not exist and all targets are absolute.

## Structure
- Package pc_pkg: the pc_op_e enum and a localparam function for the count width.
- Sub-module ret_stack: a parametrised LIFO (STACK_DEPTH × INSTR_ADDR_SIZE).
  - Inputs: push, pop, push_data. Outputs: top, count, full, empty.
  - Asynchronous reset clears count only.
  - Performs no push when full and no pop when empty.
- pc_stack contains the op decode, the address register, the error flag and, under the macro, the relative adder.

## Test plan
- Reset then 3 free-running cycles → instr_addr 0,1,2,3; stack_empty=1, stack_err=0.
- At instr_addr=3, call with jmp_addr=20 → instr_addr=20, count=1. At 21, ret → instr_addr=4, count=0.
- Nested calls at 1→10, 11→15, 16→25; then 3 rets → instr_addr 17, 12, 2.
- Fill all 4 entries, then a 5th call with jmp_addr=7 → instr_addr=7, count=4, stack_err=1. A later ret returns to the 4th caller + 1.
- Ret on empty at instr_addr=31 → instr_addr=0 (wrap), stack_err=1. Check that stall held with call=1 leaves instr_addr and count unchanged.
- With PC_REL_BRANCH_EN: at instr_addr=10, jmp+rel with jmp_addr=5'b11101 (−3) → 7. Separately, assert rst asynchronously mid-call sequence → outputs return to reset values before the next edge.
